lfsr_rng: RTL and testbench

Parametrised pseudo-random source for the game FSMs: a WIDTH-bit Galois LFSR with a built-in tick divider, optional timing-entropy mixing, seed loading, zero-lock protection and a request/valid handshake that returns a fresh OUT_W-bit value. It sits beside the main game FSM, which pulses `req` whenever it needs a new random symbol and consumes `rnd` on `rnd_valid`.

---
 rtl/lfsr_rng.sv | 110 +++++++++++
 tb/tb_lfsr_rng.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Galois LFSR random source with a free-running tick divider, seed loading,
// a zero-lock guard and a req/rnd_valid handshake returning OUT_W-bit words.
module lfsr_rng #(
   parameter int unsigned           WIDTH  = 16,
   parameter logic [WIDTH-1:0]      TAPS   = 16'hB400,
   parameter int unsigned           OUT_W  = 2,
   parameter int unsigned           DIV    = 500,
   parameter logic [WIDTH-1:0]      SEED   = 16'h0001,
   parameter bit                    MIX_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req,
   output logic             busy,
   output logic             rnd_valid,
   output logic [OUT_W-1:0] rnd,
   output logic [WIDTH-1:0] state_out
);

   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic [1:0] {IDLE, GEN, OUT} fsm_t;

   fsm_t             fsm;
   logic [WIDTH-1:0] lfsr;
   logic [CW-1:0]    cnt;
   logic             phase;
   logic [BCW-1:0]   bcnt;
   logic [OUT_W-1:0] sr;
   logic [OUT_W-1:0] sr_shift;
   logic             tick;
   logic             fb;
   logic [WIDTH-1:0] raw_next;
   logic [WIDTH-1:0] step_val;

   assign tick      = (cnt == CW'(DIV - 1));
   assign state_out = lfsr;

   // Feedback bit doubles as the output bit shifted into the word during GEN.
   always_comb begin
      fb       = lfsr[0] ^ (MIX_EN & phase);
      raw_next = (lfsr >> 1) ^ (fb ? TAPS : '0);
      step_val = (raw_next == '0) ? SEED : raw_next;
   end

   generate
      if (OUT_W == 1) begin : g_sr1
         assign sr_shift = fb;
      end else begin : g_srn
         assign sr_shift = {sr[OUT_W-2:0], fb};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm       <= IDLE;
         lfsr      <= SEED;
         cnt       <= '0;
         phase     <= 1'b0;
         bcnt      <= '0;
         sr        <= '0;
         rnd       <= '0;
         rnd_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cnt       <= tick ? '0 : cnt + 1'b1;
         if (tick) phase <= ~phase;
         rnd_valid <= 1'b0;

         if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
            fsm  <= IDLE;
            busy <= 1'b0;
         end else begin
            case (fsm)
               IDLE: begin
                  if (req) begin
                     fsm  <= GEN;
                     bcnt <= '0;
                     busy <= 1'b1;
                  end else if (en && tick) begin
                     lfsr <= step_val;
                  end
               end
               GEN: begin
                  lfsr <= step_val;
                  sr   <= sr_shift;
                  if (bcnt == BCW'(OUT_W - 1)) fsm <= OUT;
                  else                         bcnt <= bcnt + 1'b1;
               end
               OUT: begin
                  rnd       <= sr;
                  rnd_valid <= 1'b1;
                  fsm       <= IDLE;
                  busy      <= 1'b0;
               end
               default: begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: 4-bit LFSR (taps 1100, seed 0001, DIV=4),
// one instance without and one with phase mixing.
module tb_lfsr_rng;

   logic       clk;
   logic       rst, en, seed_load, req;
   logic [3:0] seed_in;
   logic       busy, rnd_valid;
   logic [1:0] rnd;
   logic [3:0] state_out;

   logic       rst2, en2;
   logic       busy2, rnd_valid2;
   logic [1:0] rnd2;
   logic [3:0] state_out2;

   int checks   = 0;
   int failures = 0;

   lfsr_rng #(.WIDTH(4), .TAPS(4'b1100), .OUT_W(2), .DIV(4), .SEED(4'b0001), .MIX_EN(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in), .req(req),
      .busy(busy), .rnd_valid(rnd_valid), .rnd(rnd), .state_out(state_out));

   lfsr_rng #(.WIDTH(4), .TAPS(4'b1100), .OUT_W(2), .DIV(4), .SEED(4'b0001), .MIX_EN(1'b1)) dut_mix (
      .clk(clk), .rst(rst2), .en(en2), .seed_load(1'b0), .seed_in(4'b0000), .req(1'b0),
      .busy(busy2), .rnd_valid(rnd_valid2), .rnd(rnd2), .state_out(state_out2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0; rst2 = 1'b0; en = 1'b0; en2 = 1'b0;
      seed_load = 1'b0; seed_in = 4'b0000; req = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (state_out !== 4'b0001 || busy !== 1'b0 || rnd_valid !== 1'b0 || rnd !== 2'b00) begin
         failures++;
         $display("FAIL reset: state=%b busy=%b valid=%b rnd=%b expected 0001 0 0 00",
                  state_out, busy, rnd_valid, rnd);
      end
      rst = 1'b1;
   endtask

   task automatic test_single_req();
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
      checks++;
      if (busy !== 1'b1 || state_out !== 4'b0001) begin
         failures++;
         $display("FAIL single_accept: busy=%b state=%b expected 1 0001", busy, state_out);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rnd_valid !== 1'b0 || state_out !== 4'b1100) begin
         failures++;
         $display("FAIL single_gen1: busy=%b valid=%b state=%b expected 1 0 1100", busy, rnd_valid, state_out);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rnd_valid !== 1'b0 || state_out !== 4'b0110) begin
         failures++;
         $display("FAIL single_gen2: busy=%b valid=%b state=%b expected 1 0 0110", busy, rnd_valid, state_out);
      end
      @(negedge clk);
      checks++;
      if (rnd_valid !== 1'b1 || rnd !== 2'b10 || busy !== 1'b0 || state_out !== 4'b0110) begin
         failures++;
         $display("FAIL single_out: valid=%b rnd=%b busy=%b state=%b expected 1 10 0 0110",
                  rnd_valid, rnd, busy, state_out);
      end
      @(negedge clk);
      checks++;
      if (rnd_valid !== 1'b0 || rnd !== 2'b10) begin
         failures++;
         $display("FAIL single_hold: valid=%b rnd=%b expected 0 10", rnd_valid, rnd);
      end
   endtask

   task automatic test_free_run();
      logic [3:0] seq [0:14];
      logic [3:0] exp_s;
      seq = '{4'b0001, 4'b1100, 4'b0110, 4'b0011, 4'b1101, 4'b1010, 4'b0101, 4'b1110,
              4'b0111, 4'b1111, 4'b1011, 4'b1001, 4'b1000, 4'b0100, 4'b0010};
      rst = 1'b0;
      #1;
      checks++;
      if (state_out !== 4'b0001 || rnd !== 2'b00 || rnd_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: state=%b rnd=%b valid=%b busy=%b expected 0001 00 0 0",
                  state_out, rnd, rnd_valid, busy);
      end
      en = 1'b1;
      rst = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         exp_s = seq[(k / 4) % 15];
         checks++;
         if (state_out !== exp_s) begin
            failures++;
            $display("FAIL free_run[%0d]: state=%b expected %b", k, state_out, exp_s);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_seed_load();
      seed_load = 1'b1; seed_in = 4'b1010;
      @(negedge clk);
      checks++;
      if (state_out !== 4'b1010) begin
         failures++;
         $display("FAIL seed_1010: state=%b expected 1010", state_out);
      end
      seed_in = 4'b0000;
      @(negedge clk);
      checks++;
      if (state_out !== 4'b0001) begin
         failures++;
         $display("FAIL seed_zero: state=%b expected 0001", state_out);
      end
      seed_in = 4'b1010;
      @(negedge clk);
      seed_load = 1'b0;
      req = 1'b1;
      @(negedge clk); req = 1'b0;
      checks++;
      if (state_out !== 4'b1010) begin
         failures++;
         $display("FAIL seed_accept: state=%b expected 1010", state_out);
      end
      @(negedge clk);
      checks++;
      if (state_out !== 4'b0101) begin
         failures++;
         $display("FAIL seed_step: state=%b expected 0101", state_out);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (rnd_valid !== 1'b1 || rnd !== 2'b01 || state_out !== 4'b1110) begin
         failures++;
         $display("FAIL seed_word: valid=%b rnd=%b state=%b expected 1 01 1110", rnd_valid, rnd, state_out);
      end
   endtask

   task automatic test_abort();
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
      @(negedge clk); seed_load = 1'b1; seed_in = 4'b0011;
      @(negedge clk); seed_load = 1'b0;
      checks++;
      if (state_out !== 4'b0011 || busy !== 1'b0 || rnd_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_load: state=%b busy=%b valid=%b expected 0011 0 0", state_out, busy, rnd_valid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (rnd_valid !== 1'b0 || rnd !== 2'b01 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet[%0d]: valid=%b rnd=%b busy=%b expected 0 01 0", k, rnd_valid, rnd, busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] words [0:3];
      logic       exp_v;
      words = '{2'b11, 2'b01, 2'b01, 2'b11};
      req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         exp_v = ((k % 4) == 3);
         checks++;
         if (rnd_valid !== exp_v || busy !== !exp_v) begin
            failures++;
            $display("FAIL b2b_strobe[%0d]: valid=%b busy=%b expected %b %b", k, rnd_valid, busy, exp_v, !exp_v);
         end
         if (exp_v) begin
            checks++;
            if (rnd !== words[k / 4]) begin
               failures++;
               $display("FAIL b2b_word[%0d]: rnd=%b expected %b", k / 4, rnd, words[k / 4]);
            end
         end
      end
      req = 1'b0;
      checks++;
      if (state_out !== 4'b1001) begin
         failures++;
         $display("FAIL b2b_state: state=%b expected 1001", state_out);
      end
   endtask

   task automatic test_reset_mid_gen();
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (state_out !== 4'b0001 || busy !== 1'b0 || rnd !== 2'b00 || rnd_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_gen: state=%b busy=%b rnd=%b valid=%b expected 0001 0 00 0",
                  state_out, busy, rnd, rnd_valid);
      end
      @(negedge clk); rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (rnd_valid !== 1'b0 || busy !== 1'b0 || state_out !== 4'b0001) begin
            failures++;
            $display("FAIL reset_lost_req[%0d]: valid=%b busy=%b state=%b expected 0 0 0001",
                     k, rnd_valid, busy, state_out);
         end
      end
   endtask

   task automatic test_mix();
      @(negedge clk); rst2 = 1'b1;
      repeat (4) @(negedge clk);
      en2 = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (state_out2 !== 4'b0001) begin
         failures++;
         $display("FAIL mix_zero_guard: state=%b expected 0001", state_out2);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (state_out2 !== 4'b1100) begin
         failures++;
         $display("FAIL mix_step_phase0: state=%b expected 1100", state_out2);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (state_out2 !== 4'b1010) begin
         failures++;
         $display("FAIL mix_step_phase1: state=%b expected 1010", state_out2);
      end
   endtask

   initial begin
      test_reset();
      test_single_req();
      test_free_run();
      test_seed_load();
      test_abort();
      test_back_to_back();
      test_reset_mid_gen();
      test_mix();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
